microwave_timer_ctrl: RTL and testbench

Control stage directly upstream of the MM:SS countdown counter chain (minutes-units mod10, seconds-tens mod6, seconds-units mod10).
- Collects keypad digits into a 3-digit BCD entry register.
- Drives the chain's data, loadn, clrn and en inputs.
- Generates the 1 Hz decrement tick.
- Consumes the chain's all-zero flag to finish cooking.
- Owns magnetron enable and the done indication.

---
 rtl/microwave_pkg.sv | 42 ++++
 rtl/tick_prescaler.sv | 37 +++
 rtl/microwave_timer_ctrl.sv | 139 +++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave countdown control slice:
// FSM state codes, BCD limits, default tick divider and entry helpers.
package microwave_pkg;

    // Controller states
    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SET   = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd3;
    localparam logic [STATE_W-1:0] ST_PAUSE = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

    // BCD limits: keypad digits and the seconds-tens counter range
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

    // Clock cycles per 1 s countdown tick
    localparam int unsigned DEFAULT_TICK_DIV = 100;

    // Three-digit M:SS entry register
    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
    } entry_t;

    // The seconds-tens counter only counts 0..5, so larger keyed values are clamped on load
    function automatic logic [3:0] sat_tens(input logic [3:0] v);
        return (v > BCD_MAX_TENS) ? BCD_MAX_TENS : v;
    endfunction

    // Keypad entry shifts left one digit; the new digit lands in seconds-units
    function automatic entry_t shift_in(input entry_t e, input logic [3:0] d);
        entry_t r;
        r.min   = e.sec_t;
        r.sec_t = e.sec_u;
        r.sec_u = d;
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to the 1 s countdown tick. Counts 0..TICK_DIV-1 and
// pulses tick on the last count; hold freezes the phase, sync_reset restarts it.
module tick_prescaler
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic clr,
    input  logic sync_reset,
    input  logic hold,
    output logic tick
);

    localparam int unsigned     CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);

    // Phase counter: restart on sync_reset, freeze on hold, else count and wrap
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (sync_reset) begin
            r_cnt <= '0;
        end else if (!hold) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

    // A held phase never emits its tick, so a suppressed tick is replayed on resume
    assign tick = w_at_last && !hold && !sync_reset;

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Control stage in front of the MM:SS countdown chain: keypad entry,
// chain load/clear/decrement control, 1 s tick generation, magnetron and done.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       zero_all,
    output logic [3:0] data_min,
    output logic [3:0] data_sec_t,
    output logic [3:0] data_sec_u,
    output logic       loadn,
    output logic       clrn_cnt,
    output logic       en_cnt,
    output logic       mag_on,
    output logic       done
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    entry_t             r_entry;
    entry_t             w_entry_nxt;

    logic w_digit_ok;
    logic w_entry_nz;
    logic w_halt;
    logic w_pre_rst;
    logic w_pre_hold;
    logic w_tick;

    assign w_digit_ok = digit_valid && (digit <= BCD_MAX_DIGIT);
    assign w_entry_nz = (r_entry != '0);
    assign w_halt     = stop || !door_closed;

    // Phase restarts during LOAD so the first tick lands TICK_DIV cycles into RUN;
    // it is frozen outside RUN and on the cycle RUN is abandoned.
    assign w_pre_rst  = (r_state == ST_LOAD);
    assign w_pre_hold = (r_state != ST_RUN) || w_halt;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .clr        (clr),
        .sync_reset (w_pre_rst),
        .hold       (w_pre_hold),
        .tick       (w_tick)
    );

    // Next state and entry register; stop always takes priority over start
    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        case (r_state)
            ST_IDLE: begin
                if (stop) begin
                    w_entry_nxt = '0;
                end else if (w_digit_ok) begin
                    w_entry_nxt = shift_in(r_entry, digit);
                    w_state_nxt = ST_SET;
                end
            end
            ST_SET: begin
                // A start that launches the cook wins over a digit in the same cycle,
                // so the chain loads exactly the value that was checked for non-zero.
                if (stop) begin
                    w_entry_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (start && door_closed && w_entry_nz) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_digit_ok) begin
                    w_entry_nxt = shift_in(r_entry, digit);
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // zero_all is ignored on a tick cycle: the chain is still mid-decrement
                if (w_halt) begin
                    w_state_nxt = ST_PAUSE;
                end else if (zero_all && !w_tick) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_entry_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (start && door_closed) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    w_entry_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_digit_ok) begin
                    w_entry_nxt = shift_in('0, digit);
                    w_state_nxt = ST_SET;
                end
            end
            default: begin
                w_entry_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and entry registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_entry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_entry <= w_entry_nxt;
        end
    end

    // Outputs decode directly from state so an async reset drops them at once
    assign clrn_cnt   = !((r_state == ST_IDLE) || (r_state == ST_SET));
    assign loadn      = (r_state != ST_LOAD);
    assign mag_on     = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign en_cnt     = w_tick;

    assign data_min   = r_entry.min;
    assign data_sec_t = sat_tens(r_entry.sec_t);
    assign data_sec_u = r_entry.sec_u;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Self-checking bench for microwave_timer_ctrl with TICK_DIV=4. A behavioural
// model (state name, three keyed digits, tick phase, chain as total seconds)
// is compared against the DUT every cycle; directed literal checks pin the model.
module tb_microwave_timer_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       digit_valid;
    logic [3:0] digit;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       zero_all;
    logic [3:0] data_min;
    logic [3:0] data_sec_t;
    logic [3:0] data_sec_u;
    logic       loadn;
    logic       clrn_cnt;
    logic       en_cnt;
    logic       mag_on;
    logic       done;

    int n_vec = 0;
    int n_bad = 0;
    int dut_ticks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    microwave_timer_ctrl #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .clr         (clr),
        .digit_valid (digit_valid),
        .digit       (digit),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .zero_all    (zero_all),
        .data_min    (data_min),
        .data_sec_t  (data_sec_t),
        .data_sec_u  (data_sec_u),
        .loadn       (loadn),
        .clrn_cnt    (clrn_cnt),
        .en_cnt      (en_cnt),
        .mag_on      (mag_on),
        .done        (done)
    );

    typedef enum int {M_IDLE, M_SET, M_LOAD, M_RUN, M_PAUSE, M_DONE} mstate_t;

    typedef struct {
        mstate_t st;
        int      d0;    // minutes digit
        int      d1;    // seconds-tens digit (as keyed)
        int      d2;    // seconds-units digit
        int      ph;    // cycles elapsed in the current tick period
        int      secs;  // countdown chain contents, in seconds
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.st = M_IDLE; r.d0 = 0; r.d1 = 0; r.d2 = 0; r.ph = 0; r.secs = 0;
        return r;
    endfunction

    function automatic int shown_tens(int t);
        return (t > 5) ? 5 : t;
    endfunction

    function automatic bit model_en(model_t s, bit sp, bit door);
        return (s.st == M_RUN) && !sp && door && (s.ph == TD - 1);
    endfunction

    function automatic model_t model_next(model_t s, bit dv, int dg, bit st, bit sp, bit door, bit za);
        model_t n;
        bit acc;
        bit nz;
        n   = s;
        acc = dv && (dg <= 9);
        nz  = (s.d0 + s.d1 + s.d2) != 0;
        // countdown chain as a seconds total (mod 10:00 wraps like the BCD chain)
        if (s.st == M_IDLE || s.st == M_SET) n.secs = 0;
        else if (s.st == M_LOAD) n.secs = s.d0 * 60 + shown_tens(s.d1) * 10 + s.d2;
        else if (model_en(s, sp, door)) n.secs = (s.secs + 599) % 600;
        case (s.st)
            M_IDLE: begin
                if (sp) begin n.d0 = 0; n.d1 = 0; n.d2 = 0; end
                else if (acc) begin n.d0 = s.d1; n.d1 = s.d2; n.d2 = dg; n.st = M_SET; end
            end
            M_SET: begin
                if (sp) begin n.d0 = 0; n.d1 = 0; n.d2 = 0; n.st = M_IDLE; end
                else if (st && door && nz) n.st = M_LOAD;
                else if (acc) begin n.d0 = s.d1; n.d1 = s.d2; n.d2 = dg; end
            end
            M_LOAD: begin n.st = M_RUN; n.ph = 0; end
            M_RUN: begin
                if (sp || !door) n.st = M_PAUSE;
                else begin
                    if (za && s.ph != TD - 1) n.st = M_DONE;
                    n.ph = (s.ph + 1) % TD;
                end
            end
            M_PAUSE: begin
                if (sp) begin n.d0 = 0; n.d1 = 0; n.d2 = 0; n.st = M_IDLE; end
                else if (st && door) n.st = M_RUN;
            end
            M_DONE: begin
                if (sp) begin n.d0 = 0; n.d1 = 0; n.d2 = 0; n.st = M_IDLE; end
                else if (acc) begin n.d0 = 0; n.d1 = 0; n.d2 = dg; n.st = M_SET; end
            end
            default: n = model_reset();
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) m <= model_reset();
        else     m <= model_next(m, digit_valid, int'(digit), start, stop, door_closed, zero_all);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_loadn",  loadn,      (m.st == M_LOAD) ? 0 : 1);
            check("m_clrn",   clrn_cnt,   (m.st == M_IDLE || m.st == M_SET) ? 0 : 1);
            check("m_mag",    mag_on,     (m.st == M_RUN) ? 1 : 0);
            check("m_done",   done,       (m.st == M_DONE) ? 1 : 0);
            check("m_en",     en_cnt,     model_en(m, stop, door_closed) ? 1 : 0);
            check("m_min",    data_min,   m.d0);
            check("m_sec_t",  data_sec_t, shown_tens(m.d1));
            check("m_sec_u",  data_sec_u, m.d2);
            if (en_cnt === 1'b1) dut_ticks++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        digit_valid = 1'b0;
        zero_all    = (m.secs == 0);
    endtask

    task automatic key(input int d);
        digit       = 4'(d);
        digit_valid = 1'b1;
        cyc();
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && done !== 1'b1; i++) cyc();
        check(name, done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; digit_valid = 1'b0; digit = '0; start = 1'b0; stop = 1'b0;
        door_closed = 1'b1; zero_all = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        clr = 1'b0;
        chk_en = 1'b1;

        // reset values
        check("rst_loadn", loadn, 1);
        check("rst_clrn",  clrn_cnt, 0);
        check("rst_mag",   mag_on, 0);
        check("rst_done",  done, 0);
        check("rst_data",  {data_min, data_sec_t, data_sec_u}, 0);

        // entry shifting, rejection of >9, tens saturation
        key(1); key(3); key(0);
        check("entry_130", {data_min, data_sec_t, data_sec_u}, 12'h130);
        key(12);
        check("entry_rej", {data_min, data_sec_t, data_sec_u}, 12'h130);
        key(9); key(9);
        check("entry_sat", {data_min, data_sec_t, data_sec_u}, 12'h059);
        stop = 1'b1; cyc(); stop = 1'b0;
        check("stop_clear", {data_min, data_sec_t, data_sec_u}, 0);

        // 0:05 cook: one-cycle load, tick every 4 cycles, five ticks then done
        key(5);
        dut_ticks = 0;
        start = 1'b1; cyc(); start = 1'b0;
        check("load_low", loadn, 0);
        cyc();
        check("load_once", loadn, 1);
        check("run_mag", mag_on, 1);
        for (int i = 0; i < TD; i++) begin
            check("first_tick", en_cnt, (i == TD - 1) ? 1 : 0);
            cyc();
        end
        wait_done("cook5_done");
        check("cook5_ticks", dut_ticks, 5);
        check("cook5_mag", mag_on, 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        check("done_stop", done, 0);
        check("done_stop_clrn", clrn_cnt, 0);

        // async reset in RUN drops outputs immediately
        key(3);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        check("pre_rst_mag", mag_on, 1);
        clr = 1'b1;
        #1;
        check("arst_mag",   mag_on, 0);
        check("arst_clrn",  clrn_cnt, 0);
        check("arst_loadn", loadn, 1);
        cyc();
        clr = 1'b0;
        cyc();
        check("arst_data", {data_min, data_sec_t, data_sec_u}, 0);
        check("arst_done", done, 0);

        // door opens on a tick cycle; pause keeps phase; total ticks preserved
        key(7);
        dut_ticks = 0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 200 && dut_ticks < 2; i++) cyc();
        for (int i = 0; i < 2 * TD && !(m.st == M_RUN && m.ph == TD - 1); i++) cyc();
        door_closed = 1'b0;
        #1;
        check("door_tick_suppr", en_cnt, 0);
        cyc();
        check("pause_mag", mag_on, 0);
        check("pause_clrn", clrn_cnt, 1);
        repeat (3) begin
            cyc();
            check("pause_en", en_cnt, 0);
        end
        door_closed = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        check("resume_phase", en_cnt, 1);
        wait_done("cook7_done");
        check("cook7_ticks", dut_ticks, 7);

        // digit in DONE restarts entry
        key(4);
        check("done_digit", {data_min, data_sec_t, data_sec_u}, 12'h004);
        check("done_digit_st", done, 0);

        // start+stop together in SET
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        check("ss_set_loadn", loadn, 1);
        check("ss_set_clrn", clrn_cnt, 0);
        check("ss_set_data", {data_min, data_sec_t, data_sec_u}, 0);

        // start+stop together in PAUSE
        key(6);
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        check("ss_pause_in", clrn_cnt, 1);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        check("ss_pause_clrn", clrn_cnt, 0);
        check("ss_pause_data", {data_min, data_sec_t, data_sec_u}, 0);
        check("ss_pause_mag", mag_on, 0);

        // start ignored with 0:00 entry or door open
        key(0);
        start = 1'b1; cyc();
        check("zero_noload", loadn, 1);
        cyc(); start = 1'b0;
        check("zero_nomag", mag_on, 0);
        key(2);
        door_closed = 1'b0;
        start = 1'b1; cyc();
        check("door_noload", loadn, 1);
        cyc(); start = 1'b0;
        check("door_nomag", mag_on, 0);
        door_closed = 1'b1;
        stop = 1'b1; cyc(); stop = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            digit_valid = ($urandom_range(0, 5) == 0);
            digit       = 4'($urandom_range(0, 15));
            start       = ($urandom_range(0, 7) == 0);
            stop        = ($urandom_range(0, 149) == 0);
            door_closed = ($urandom_range(0, 99) != 0);
            @(posedge clk);
            #2;
            zero_all = (m.secs == 0);
        end
        digit_valid = 1'b0; start = 1'b0; stop = 1'b0; door_closed = 1'b1;
        cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
